// File: rtl/matrix_inv2x2_q_if.sv
// Handshake and data bundle for the 2x2 fixed-point matrix inverter.
// The master drives the request and matrix; the slave returns the inverse and flags.
interface matrix_inv2x2_q_if #(
  parameter int W = 16
);
  logic                start;
  logic                sym;
  logic signed [W-1:0] a;
  logic signed [W-1:0] b;
  logic signed [W-1:0] c;
  logic signed [W-1:0] d;
  logic                in_ready;
  logic signed [W-1:0] a_inv;
  logic signed [W-1:0] b_inv;
  logic signed [W-1:0] c_inv;
  logic signed [W-1:0] d_inv;
  logic                out_valid;
  logic                err_singular;
  logic                err_sat;

  modport master (
    output start, sym, a, b, c, d,
    input  in_ready, a_inv, b_inv, c_inv, d_inv, out_valid, err_singular, err_sat
  );

  modport slave (
    input  start, sym, a, b, c, d,
    output in_ready, a_inv, b_inv, c_inv, d_inv, out_valid, err_singular, err_sat
  );
endinterface

// File: rtl/matrix_inv2x2_q.sv
// 2x2 signed fixed-point matrix inverter: determinant, near-singular check,
// serial restoring reciprocal of |det|, adjugate scaling, round and saturate.
module matrix_inv2x2_q #(
  parameter int     W       = 16,
  parameter int     F       = 14,
  parameter longint DET_EPS = 0
) (
  input logic             clk,
  input logic             reset_n,
  matrix_inv2x2_q_if.slave bus
);

  localparam int DW = 2 * W + 1;        // determinant width, fraction 2F
  localparam int QW = 4 * F + 1;        // reciprocal width, unsigned Q.2F
  localparam int RW = DW + 1;           // shifted partial remainder width
  localparam int PW = W + 4 * F + 2;    // product width, fraction 3F
  localparam int CW = $clog2(QW + 1);

  localparam logic [DW-1:0]        EPS_V    = DW'(DET_EPS);
  localparam logic [CW-1:0]        CNT_LAST = CW'(QW - 1);
  localparam logic signed [PW-1:0] HALF     = PW'(1) << (2 * F - 1);
  localparam logic signed [PW-1:0] MAXV     = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV     = {{(PW-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_DET, S_CHECK, S_DIV, S_MUL, S_OUT} state_t;

  state_t state_q, state_d;

  logic signed [W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [DW-1:0]        absdet_q, absdet_d;
  logic                 neg_q, neg_d;
  logic                 sing_q, sing_d;
  logic [QW-1:0]        dq_q, dq_d;
  logic [DW-1:0]        rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [PW-1:0] pa_q, pa_d, pb_q, pb_d, pc_q, pc_d, pd_q, pd_d;
  logic signed [W-1:0]  ai_q, ai_d, bi_q, bi_d, ci_q, ci_d, di_q, di_d;
  logic                 ov_q, ov_d;
  logic                 esng_q, esng_d;
  logic                 esat_q, esat_d;

  // Round half up, then drop the 2F extra fraction bits arithmetically.
  function automatic logic signed [PW-1:0] rnd(input logic signed [PW-1:0] p);
    rnd = (p + HALF) >>> (2 * F);
  endfunction

  function automatic logic sat_hit(input logic signed [PW-1:0] v);
    sat_hit = (v > MAXV) || (v < MINV);
  endfunction

  function automatic logic signed [W-1:0] sat_w(input logic signed [PW-1:0] v);
    if (v > MAXV)      sat_w = {1'b0, {(W-1){1'b1}}};
    else if (v < MINV) sat_w = {1'b1, {(W-1){1'b0}}};
    else               sat_w = v[W-1:0];
  endfunction

  logic signed [DW-1:0] det;
  logic [RW-1:0]        rshift;
  logic [DW-1:0]        rsub;
  logic                 ge;
  logic signed [PW-1:0] recip_x;
  logic signed [PW-1:0] ra, rb, rc, rd;

  // Next-state, datapath and output-register updates for every state.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    d_d      = d_q;
    absdet_d = absdet_q;
    neg_d    = neg_q;
    sing_d   = sing_q;
    dq_d     = dq_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    pa_d     = pa_q;
    pb_d     = pb_q;
    pc_d     = pc_q;
    pd_d     = pd_q;
    ai_d     = ai_q;
    bi_d     = bi_q;
    ci_d     = ci_q;
    di_d     = di_q;
    ov_d     = 1'b0;
    esng_d   = esng_q;
    esat_d   = esat_q;

    det     = DW'(a_q) * DW'(d_q) - DW'(b_q) * DW'(c_q);
    rshift  = {rem_q, dq_q[QW-1]};
    ge      = rshift >= {1'b0, absdet_q};
    rsub    = rshift[DW-1:0] - absdet_q;
    recip_x = signed'({{(PW-QW){1'b0}}, dq_q});
    ra      = rnd(pa_q);
    rb      = rnd(pb_q);
    rc      = rnd(pc_q);
    rd      = rnd(pd_q);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.sym ? bus.b : bus.c;
          d_d     = bus.d;
          state_d = S_DET;
        end
      end
      S_DET: begin
        absdet_d = det[DW-1] ? -det : det;
        neg_d    = det[DW-1];
        state_d  = S_CHECK;
      end
      S_CHECK: begin
        if (absdet_q <= EPS_V) begin
          sing_d  = 1'b1;
          state_d = S_OUT;
        end else begin
          sing_d  = 1'b0;
          dq_d    = {1'b1, {(QW-1){1'b0}}};
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        // Dividend bits shift out of the top while quotient bits enter at the bottom.
        dq_d  = {dq_q[QW-2:0], ge};
        rem_d = ge ? rsub : rshift[DW-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_MUL;
      end
      S_MUL: begin
        pa_d = PW'(d_q) * recip_x;
        pb_d = -PW'(b_q) * recip_x;
        pc_d = -PW'(c_q) * recip_x;
        pd_d = PW'(a_q) * recip_x;
        if (neg_q) begin
          pa_d = -pa_d;
          pb_d = -pb_d;
          pc_d = -pc_d;
          pd_d = -pd_d;
        end
        state_d = S_OUT;
      end
      S_OUT: begin
        if (sing_q) begin
          ai_d   = '0;
          bi_d   = '0;
          ci_d   = '0;
          di_d   = '0;
          esng_d = 1'b1;
          esat_d = 1'b0;
        end else begin
          ai_d   = sat_w(ra);
          bi_d   = sat_w(rb);
          ci_d   = sat_w(rc);
          di_d   = sat_w(rd);
          esng_d = 1'b0;
          esat_d = sat_hit(ra) | sat_hit(rb) | sat_hit(rc) | sat_hit(rd);
        end
        ov_d    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Operand, divider, product and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      d_q      <= '0;
      absdet_q <= '0;
      neg_q    <= 1'b0;
      sing_q   <= 1'b0;
      dq_q     <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      pa_q     <= '0;
      pb_q     <= '0;
      pc_q     <= '0;
      pd_q     <= '0;
      ai_q     <= '0;
      bi_q     <= '0;
      ci_q     <= '0;
      di_q     <= '0;
      ov_q     <= 1'b0;
      esng_q   <= 1'b0;
      esat_q   <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      d_q      <= d_d;
      absdet_q <= absdet_d;
      neg_q    <= neg_d;
      sing_q   <= sing_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      pa_q     <= pa_d;
      pb_q     <= pb_d;
      pc_q     <= pc_d;
      pd_q     <= pd_d;
      ai_q     <= ai_d;
      bi_q     <= bi_d;
      ci_q     <= ci_d;
      di_q     <= di_d;
      ov_q     <= ov_d;
      esng_q   <= esng_d;
      esat_q   <= esat_d;
    end
  end

  assign bus.in_ready     = (state_q == S_IDLE);
  assign bus.a_inv        = ai_q;
  assign bus.b_inv        = bi_q;
  assign bus.c_inv        = ci_q;
  assign bus.d_inv        = di_q;
  assign bus.out_valid    = ov_q;
  assign bus.err_singular = esng_q;
  assign bus.err_sat      = esat_q;

endmodule

// File: tb/tb_matrix_inv2x2_q.sv
// Directed bench for matrix_inv2x2_q: hand-computed inverses, latency,
// handshake, near-singular threshold and mid-operation reset.
module tb_matrix_inv2x2_q;
  localparam int W    = 16;
  localparam int F    = 14;
  localparam int NOM  = 4 * F + 6;
  localparam int SING = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  matrix_inv2x2_q_if #(.W(W)) bus0 ();
  matrix_inv2x2_q_if #(.W(W)) bus1 ();

  matrix_inv2x2_q #(.W(W), .F(F)) dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0)
  );
  matrix_inv2x2_q #(.W(W), .F(F), .DET_EPS(64'd1048576)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) bus1.start = v;
    else     bus0.start = v;
  endtask

  task automatic drive(input bit sel, input logic sym,
                       input logic signed [W-1:0] a, b, c, d);
    if (sel) begin
      bus1.sym = sym; bus1.a = a; bus1.b = b; bus1.c = c; bus1.d = d; bus1.start = 1'b1;
    end else begin
      bus0.sym = sym; bus0.a = a; bus0.b = b; bus0.c = c; bus0.d = d; bus0.start = 1'b1;
    end
  endtask

  task automatic get_out(input bit sel, output logic signed [W-1:0] ai, bi, ci, di,
                         output logic ov, es, esat, rdy);
    if (sel) begin
      ai = bus1.a_inv; bi = bus1.b_inv; ci = bus1.c_inv; di = bus1.d_inv;
      ov = bus1.out_valid; es = bus1.err_singular; esat = bus1.err_sat; rdy = bus1.in_ready;
    end else begin
      ai = bus0.a_inv; bi = bus0.b_inv; ci = bus0.c_inv; di = bus0.d_inv;
      ov = bus0.out_valid; es = bus0.err_singular; esat = bus0.err_sat; rdy = bus0.in_ready;
    end
  endtask

  // Called at a negedge with start already driven; returns at the negedge of the
  // out_valid cycle. poke_at >= 0 pulses a junk start while busy at that cycle.
  task automatic wait_valid(input bit sel, input string tag, input int poke_at,
                            output int lat);
    logic signed [W-1:0] ai, bi, ci, di;
    logic ov, es, esat, rdy;
    @(posedge clk);
    @(negedge clk);
    set_start(sel, 1'b0);
    lat = 1;
    get_out(sel, ai, bi, ci, di, ov, es, esat, rdy);
    while (!ov && lat < 300) begin
      if (lat == 5) chk({tag, ".busy_rdy"}, rdy, 0);
      if (lat == poke_at) drive(sel, 1'b1, 16'sd100, 16'sd50, 16'sd7, 16'sd100);
      else if (lat == poke_at + 1) set_start(sel, 1'b0);
      @(negedge clk);
      lat++;
      get_out(sel, ai, bi, ci, di, ov, es, esat, rdy);
    end
    if (!ov) chk({tag, ".timeout"}, ov, 1);
    chk({tag, ".vld_rdy"}, rdy, 1);
  endtask

  task automatic check_res(input bit sel, input string tag,
                           input longint ea, eb, ec, ed, input longint es_e, esat_e);
    logic signed [W-1:0] ai, bi, ci, di;
    logic ov, es, esat, rdy;
    get_out(sel, ai, bi, ci, di, ov, es, esat, rdy);
    chk({tag, ".a"}, ai, ea);
    chk({tag, ".b"}, bi, eb);
    chk({tag, ".c"}, ci, ec);
    chk({tag, ".d"}, di, ed);
    chk({tag, ".sing"}, es, es_e);
    chk({tag, ".sat"}, esat, esat_e);
  endtask

  task automatic check_pulse(input bit sel, input string tag);
    logic signed [W-1:0] ai, bi, ci, di;
    logic ov, es, esat, rdy;
    @(negedge clk);
    get_out(sel, ai, bi, ci, di, ov, es, esat, rdy);
    chk({tag, ".pulse"}, ov, 0);
  endtask

  task automatic run(input bit sel, input string tag, input logic sym,
                     input logic signed [W-1:0] a, b, c, d, input int exp_lat,
                     input longint ea, eb, ec, ed, es_e, esat_e);
    int lat;
    @(negedge clk);
    drive(sel, sym, a, b, c, d);
    wait_valid(sel, tag, -1, lat);
    chk({tag, ".lat"}, lat, exp_lat);
    check_res(sel, tag, ea, eb, ec, ed, es_e, esat_e);
    check_pulse(sel, tag);
  endtask

  initial begin
    int lat;
    int nv;
    logic signed [W-1:0] ai, bi, ci, di;
    logic ov, es, esat, rdy;

    reset_n = 1'b1;
    bus0.start = 1'b0; bus0.sym = 1'b0; bus0.a = '0; bus0.b = '0; bus0.c = '0; bus0.d = '0;
    bus1.start = 1'b0; bus1.sym = 1'b0; bus1.a = '0; bus1.b = '0; bus1.c = '0; bus1.d = '0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    get_out(0, ai, bi, ci, di, ov, es, esat, rdy);
    chk("rst.rdy", rdy, 1);
    chk("rst.vld", ov, 0);
    chk("rst.a", ai, 0);
    chk("rst.sing", es, 0);
    reset_n = 1'b1;

    run(0, "ident", 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd16384, NOM,
        16384, 0, 0, 16384, 0, 0);
    run(0, "sym", 1'b1, 16'sd16384, 16'sd8192, 16'sh7FFF, 16'sd16384, NOM,
        21845, -10923, -10923, 21845, 0, 0);
    run(0, "sat", 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd8192, NOM,
        16384, 0, 0, 32767, 0, 1);
    run(0, "sing", 1'b0, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192, SING,
        0, 0, 0, 0, 1, 0);
    run(0, "negdet", 1'b0, 16'sd0, 16'sd16384, 16'sd16384, 16'sd0, NOM,
        0, 16384, 16384, 0, 0, 0);
    run(0, "mneg", 1'b0, -16'sd32768, 16'sd0, 16'sd0, -16'sd32768, NOM,
        -8192, 0, 0, -8192, 0, 0);
    run(0, "mnegb", 1'b0, 16'sd0, -16'sd32768, 16'sd16384, 16'sd0, NOM,
        0, 16384, -8192, 0, 0, 0);

    // Busy start ignored, then a start in the out_valid cycle is accepted.
    @(negedge clk);
    drive(0, 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd16384);
    wait_valid(0, "busy", 10, lat);
    chk("busy.lat", lat, NOM);
    check_res(0, "busy", 16384, 0, 0, 16384, 0, 0);
    drive(0, 1'b1, 16'sd16384, 16'sd8192, 16'sd0, 16'sd16384);
    wait_valid(0, "b2b", -1, lat);
    chk("b2b.lat", lat, NOM);
    check_res(0, "b2b", 21845, -10923, -10923, 21845, 0, 0);
    check_pulse(0, "b2b");

    // Programmable threshold: det = 2^19 raw is at or below 2^20.
    run(1, "eps", 1'b0, 16'sd1024, 16'sd0, 16'sd0, 16'sd512, SING,
        0, 0, 0, 0, 1, 0);
    run(1, "epsid", 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd16384, NOM,
        16384, 0, 0, 16384, 0, 0);

    // Reset during the division aborts with no out_valid.
    run(0, "presat", 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd8192, NOM,
        16384, 0, 0, 32767, 0, 1);
    @(negedge clk);
    drive(0, 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd16384);
    @(posedge clk);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    get_out(0, ai, bi, ci, di, ov, es, esat, rdy);
    chk("arst.rdy", rdy, 1);
    chk("arst.a", ai, 0);
    chk("arst.d", di, 0);
    chk("arst.sat", esat, 0);
    chk("arst.vld", ov, 0);
    @(negedge clk);
    reset_n = 1'b1;
    nv = 0;
    repeat (80) begin
      @(negedge clk);
      get_out(0, ai, bi, ci, di, ov, es, esat, rdy);
      if (ov) nv++;
    end
    chk("arst.novld", nv, 0);
    run(0, "postrst", 1'b0, 16'sd16384, 16'sd0, 16'sd0, 16'sd8192, NOM,
        16384, 0, 0, 32767, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
